// File: rtl/adc_pipe_buffer_if.sv
// Sample/host pipe bundle for adc_pipe_buffer: ADC write side, host pipe-out
// read side, and status readback.
interface adc_pipe_buffer_if #(
  parameter int AW = 10
);
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        capture_en;
  logic        flush;
  logic        pipe_read;
  logic [15:0] pipe_dout;
  logic        pipe_ready;
  logic [AW:0] fifo_count;
  logic        buf_overflow;
  logic        rd_err;
  logic [7:0]  overflow_count;

  modport master (
    output sample_in, sample_valid, capture_en, flush, pipe_read,
    input  pipe_dout, pipe_ready, fifo_count, buf_overflow, rd_err, overflow_count
  );

  modport slave (
    input  sample_in, sample_valid, capture_en, flush, pipe_read,
    output pipe_dout, pipe_ready, fifo_count, buf_overflow, rd_err, overflow_count
  );
endinterface

// File: rtl/adc_pipe_buffer.sv
// Block-throttled ADC sample FIFO feeding a host pipe-out endpoint.
// Define ADC_PIPE_OVF_COUNT_EN to enable the saturating dropped-sample counter.
module adc_pipe_buffer #(
  parameter int DEPTH      = 1024,
  parameter int BLOCK_SIZE = 256,
  parameter int AW         = 10
) (
  input  logic ti_clk,
  input  logic rst,
  adc_pipe_buffer_if.slave bus
);

  // state | meaning
  // IDLE  | fewer than a block buffered, or just finished a burst
  // READY | a full block is buffered, pipe_ready asserted
  // BURST | host is reading the current block
  typedef enum logic [1:0] {IDLE, READY, BURST} state_t;

  localparam int BW = $clog2(BLOCK_SIZE) + 1;

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic [BW-1:0] burst_cnt;
  logic [15:0]   rd_q;
  logic          dout_zero;
  logic          ready_q;
  logic          ovf_q;
  logic          rd_err_q;
  logic          full;
  logic          in_burst;
  logic          wr_en;
  logic          rd_en;
  logic          rd_bad;
  logic          drop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign in_burst = (state == READY) || (state == BURST);
  assign wr_en    = !bus.flush && bus.sample_valid && bus.capture_en && !full;
  assign drop     = !bus.flush && bus.sample_valid && bus.capture_en && full;
  assign rd_en    = !bus.flush && bus.pipe_read && in_burst && (count != '0);
  assign rd_bad   = !bus.flush && bus.pipe_read && !rd_en;

  always_comb begin
    count_nxt = count;
    if (wr_en && !rd_en)
      count_nxt = count + 1'b1;
    else if (rd_en && !wr_en)
      count_nxt = count - 1'b1;
  end

  // Reset-free so the array and its read register map onto block RAM.
  always_ff @(posedge ti_clk) begin
    if (wr_en)
      mem[wr_ptr] <= bus.sample_in;
    if (rd_en)
      rd_q <= mem[rd_ptr];
  end

  always_ff @(posedge ti_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      burst_cnt <= '0;
      ready_q   <= 1'b0;
      ovf_q     <= 1'b0;
      rd_err_q  <= 1'b0;
      dout_zero <= 1'b1;
    end else if (bus.flush) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      burst_cnt <= '0;
      ready_q   <= 1'b0;
      ovf_q     <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if (drop)
        ovf_q <= 1'b1;
      // An illegal read zeroes the output word; a legal pop exposes RAM data.
      if (rd_bad) begin
        rd_err_q  <= 1'b1;
        dout_zero <= 1'b1;
      end else if (rd_en) begin
        dout_zero <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (count_nxt >= (AW+1)'(BLOCK_SIZE)) begin
            state   <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          if (rd_en) begin
            state     <= BURST;
            ready_q   <= 1'b0;
            burst_cnt <= BW'(1);
          end
        end
        BURST: begin
          if (rd_en) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == BW'(BLOCK_SIZE - 1))
              state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADC_PIPE_OVF_COUNT_EN
  logic [7:0] ovf_cnt;

  always_ff @(posedge ti_clk or posedge rst) begin
    if (rst)
      ovf_cnt <= 8'h00;
    else if (bus.flush)
      ovf_cnt <= 8'h00;
    else if (drop && ovf_cnt != 8'hFF)
      ovf_cnt <= ovf_cnt + 1'b1;
  end

  assign bus.overflow_count = ovf_cnt;
`else
  assign bus.overflow_count = 8'h00;
`endif

  assign bus.pipe_dout    = dout_zero ? 16'h0000 : rd_q;
  assign bus.pipe_ready   = ready_q;
  assign bus.fifo_count   = count;
  assign bus.buf_overflow = ovf_q;
  assign bus.rd_err       = rd_err_q;

endmodule

// File: tb/tb_adc_pipe_buffer.sv
// Directed self-checking bench for adc_pipe_buffer (default 1024/256 geometry).
module tb_adc_pipe_buffer;

  logic ti_clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0] blk [256];
  bit          blk_timeout;
  bit          blk_ready_high;

`ifdef ADC_PIPE_OVF_COUNT_EN
  localparam logic [7:0] OVF_EXP = 8'd3;
`else
  localparam logic [7:0] OVF_EXP = 8'd0;
`endif

  adc_pipe_buffer_if #(.AW(10)) bus ();

  adc_pipe_buffer #(.DEPTH(1024), .BLOCK_SIZE(256), .AW(10)) dut (
    .ti_clk (ti_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 ti_clk = ~ti_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] d);
    bus.sample_in    = d;
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  // Waits (bounded) for pipe_ready, then reads one block into blk[].
  task automatic read_block();
    int n = 0;
    blk_timeout    = 1'b0;
    blk_ready_high = 1'b0;
    while (bus.pipe_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (bus.pipe_ready !== 1'b1) begin
      blk_timeout = 1'b1;
    end else begin
      for (int i = 0; i < 256; i++) begin
        bus.pipe_read = 1'b1;
        step();
        blk[i] = bus.pipe_dout;
        if (bus.pipe_ready !== 1'b0) blk_ready_high = 1'b1;
      end
    end
    bus.pipe_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #100;
    rst = 1'b0;
    step();
    vectors++; if (bus.pipe_dout !== 16'h0) begin miscompares++; $display("FAIL reset_dout got %h exp 0000", bus.pipe_dout); end
    vectors++; if (bus.pipe_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b exp 0", bus.pipe_ready); end
    vectors++; if (bus.fifo_count !== 11'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", bus.fifo_count); end
    vectors++; if (bus.buf_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0", bus.buf_overflow); end
    vectors++; if (bus.rd_err !== 1'b0) begin miscompares++; $display("FAIL reset_rderr got %b exp 0", bus.rd_err); end
    vectors++; if (bus.overflow_count !== 8'h0) begin miscompares++; $display("FAIL reset_ovfcnt got %0d exp 0", bus.overflow_count); end
  endtask

  task automatic test_single_block();
    for (int i = 0; i < 256; i++) begin
      write_word(16'(i));
      if (i == 254) begin
        vectors++; if (bus.pipe_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready_early got %b exp 0", bus.pipe_ready); end
      end
    end
    vectors++; if (bus.pipe_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready_edge got %b exp 1", bus.pipe_ready); end
    vectors++; if (bus.fifo_count !== 11'd256) begin miscompares++; $display("FAIL single_count got %0d exp 256", bus.fifo_count); end
    read_block();
    vectors++; if (blk_timeout !== 1'b0) begin miscompares++; $display("FAIL single_wait got timeout exp ready"); end
    for (int i = 0; i < 256; i++) begin
      vectors++; if (blk[i] !== 16'(i)) begin miscompares++; $display("FAIL single_data[%0d] got %h exp %h", i, blk[i], 16'(i)); end
    end
    vectors++; if (blk_ready_high !== 1'b0) begin miscompares++; $display("FAIL single_ready_burst got 1 exp 0"); end
    vectors++; if (bus.fifo_count !== 11'd0) begin miscompares++; $display("FAIL single_count_end got %0d exp 0", bus.fifo_count); end
    step();
    vectors++; if (bus.pipe_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready_after got %b exp 0", bus.pipe_ready); end
  endtask

  task automatic test_overflow();
    do_flush();
    for (int i = 0; i < 1024; i++) write_word(16'h1000 + 16'(i));
    vectors++; if (bus.fifo_count !== 11'd1024) begin miscompares++; $display("FAIL ovf_fill_count got %0d exp 1024", bus.fifo_count); end
    vectors++; if (bus.buf_overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_fill_flag got %b exp 0", bus.buf_overflow); end
    for (int i = 0; i < 3; i++) write_word(16'hDEAD);
    vectors++; if (bus.buf_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b exp 1", bus.buf_overflow); end
    vectors++; if (bus.fifo_count !== 11'd1024) begin miscompares++; $display("FAIL ovf_count got %0d exp 1024", bus.fifo_count); end
    vectors++; if (bus.overflow_count !== OVF_EXP) begin miscompares++; $display("FAIL ovf_counter got %0d exp %0d", bus.overflow_count, OVF_EXP); end
    for (int b = 0; b < 4; b++) begin
      read_block();
      vectors++; if (blk_timeout !== 1'b0) begin miscompares++; $display("FAIL ovf_wait[%0d] got timeout exp ready", b); end
      for (int i = 0; i < 256; i++) begin
        vectors++;
        if (blk[i] !== 16'h1000 + 16'(b*256 + i)) begin
          miscompares++;
          $display("FAIL ovf_data[%0d] got %h exp %h", b*256 + i, blk[i], 16'h1000 + 16'(b*256 + i));
        end
      end
    end
    vectors++; if (bus.fifo_count !== 11'd0) begin miscompares++; $display("FAIL ovf_drain_count got %0d exp 0", bus.fifo_count); end
    vectors++; if (bus.rd_err !== 1'b0) begin miscompares++; $display("FAIL ovf_rderr got %b exp 0", bus.rd_err); end
    vectors++; if (bus.buf_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b exp 1", bus.buf_overflow); end
  endtask

  task automatic test_wrap();
    int written = 0;
    int model = 0;
    logic [15:0] wr_val = 16'h5000;
    logic [15:0] rd_val = 16'h5000;
    do_flush();
    vectors++; if (bus.buf_overflow !== 1'b0) begin miscompares++; $display("FAIL wrap_flush_ovf got %b exp 0", bus.buf_overflow); end
    vectors++; if (bus.overflow_count !== 8'h0) begin miscompares++; $display("FAIL wrap_flush_ovfcnt got %0d exp 0", bus.overflow_count); end
    while (written < 3000) begin
      for (int i = 0; i < 300 && written < 3000; i++) begin
        write_word(wr_val);
        wr_val++;
        written++;
        model++;
      end
      while (model >= 256) begin
        read_block();
        vectors++; if (blk_timeout !== 1'b0) begin miscompares++; $display("FAIL wrap_wait got timeout exp ready"); end
        for (int i = 0; i < 256; i++) begin
          vectors++; if (blk[i] !== rd_val) begin miscompares++; $display("FAIL wrap_data got %h exp %h", blk[i], rd_val); end
          rd_val++;
        end
        model -= 256;
      end
    end
    vectors++; if (bus.fifo_count !== 11'(model)) begin miscompares++; $display("FAIL wrap_count got %0d exp %0d", bus.fifo_count, model); end
    vectors++; if (bus.rd_err !== 1'b0) begin miscompares++; $display("FAIL wrap_rderr got %b exp 0", bus.rd_err); end
  endtask

  task automatic test_protocol_error();
    do_flush();
    for (int i = 0; i < 10; i++) write_word(16'h2200 + 16'(i));
    vectors++; if (bus.pipe_ready !== 1'b0) begin miscompares++; $display("FAIL proto_ready got %b exp 0", bus.pipe_ready); end
    bus.pipe_read = 1'b1;
    step();
    bus.pipe_read = 1'b0;
    vectors++; if (bus.rd_err !== 1'b1) begin miscompares++; $display("FAIL proto_rderr got %b exp 1", bus.rd_err); end
    vectors++; if (bus.fifo_count !== 11'd10) begin miscompares++; $display("FAIL proto_count got %0d exp 10", bus.fifo_count); end
    vectors++; if (bus.pipe_dout !== 16'h0) begin miscompares++; $display("FAIL proto_dout got %h exp 0000", bus.pipe_dout); end
    do_flush();
    vectors++; if (bus.rd_err !== 1'b0) begin miscompares++; $display("FAIL proto_flush_rderr got %b exp 0", bus.rd_err); end
    bus.pipe_read = 1'b1;
    write_word(16'h3333);
    bus.pipe_read = 1'b0;
    vectors++; if (bus.fifo_count !== 11'd1) begin miscompares++; $display("FAIL empty_wr_count got %0d exp 1", bus.fifo_count); end
    vectors++; if (bus.rd_err !== 1'b1) begin miscompares++; $display("FAIL empty_wr_rderr got %b exp 1", bus.rd_err); end
  endtask

  task automatic test_flush_capture();
    do_flush();
    bus.pipe_read = 1'b1;
    step();
    bus.pipe_read = 1'b0;
    for (int i = 0; i < 256; i++) write_word(16'h7000 + 16'(i));
    vectors++; if (bus.pipe_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready_pre got %b exp 1", bus.pipe_ready); end
    bus.pipe_read = 1'b1;
    for (int i = 0; i < 10; i++) step();
    vectors++; if (bus.pipe_dout !== 16'h7009) begin miscompares++; $display("FAIL flush_dout_pre got %h exp 7009", bus.pipe_dout); end
    vectors++; if (bus.rd_err !== 1'b1) begin miscompares++; $display("FAIL flush_rderr_pre got %b exp 1", bus.rd_err); end
    bus.flush = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.pipe_read = 1'b0;
    vectors++; if (bus.pipe_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready got %b exp 0", bus.pipe_ready); end
    vectors++; if (bus.fifo_count !== 11'd0) begin miscompares++; $display("FAIL flush_count got %0d exp 0", bus.fifo_count); end
    vectors++; if (bus.rd_err !== 1'b0) begin miscompares++; $display("FAIL flush_rderr got %b exp 0", bus.rd_err); end
    vectors++; if (bus.pipe_dout !== 16'h7009) begin miscompares++; $display("FAIL flush_dout_hold got %h exp 7009", bus.pipe_dout); end
    for (int i = 0; i < 256; i++) write_word(16'h7100 + 16'(i));
    read_block();
    vectors++; if (blk_timeout !== 1'b0) begin miscompares++; $display("FAIL flush_reblock_wait got timeout exp ready"); end
    vectors++; if (blk[0] !== 16'h7100) begin miscompares++; $display("FAIL flush_reblock_first got %h exp 7100", blk[0]); end
    vectors++; if (blk[255] !== 16'h71FF) begin miscompares++; $display("FAIL flush_reblock_last got %h exp 71ff", blk[255]); end
    bus.capture_en = 1'b0;
    for (int i = 0; i < 5; i++) write_word(16'hBEEF);
    bus.capture_en = 1'b1;
    vectors++; if (bus.fifo_count !== 11'd0) begin miscompares++; $display("FAIL capture_count got %0d exp 0", bus.fifo_count); end
    vectors++; if (bus.buf_overflow !== 1'b0) begin miscompares++; $display("FAIL capture_ovf got %b exp 0", bus.buf_overflow); end
  endtask

  initial begin
    bus.sample_in    = 16'h0;
    bus.sample_valid = 1'b0;
    bus.capture_en   = 1'b1;
    bus.flush        = 1'b0;
    bus.pipe_read    = 1'b0;
    test_reset();
    test_single_block();
    test_overflow();
    test_wrap();
    test_protocol_error();
    test_flush_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
